// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One radix-2 step per cycle, sign fixup and commit in a final cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic               dvz_q, dvz_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;

  logic               sgn_op;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_hi;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    sgn_op = ~op[0];
    rs_neg = sgn_op & rs_data[WIDTH-1];
    rt_neg = sgn_op & rt_data[WIDTH-1];
    rs_mag = rs_neg ? -rs_data : rs_data;
    rt_mag = rt_neg ? -rt_data : rt_data;
  end

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + (acc_q[0] ? {1'b0, opb_q} : '0);
    // upper half after the left shift, one extra bit for the trial subtract
    div_hi   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_hi - {1'b0, opb_q};
    prod     = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo      = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0]
                                   : acc_q[WIDTH-1:0];
    rem      = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH]
                       : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dvz_d    = dvz_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d  = S_CALC;
          is_div_d = op[1];
          neg_a_d  = rs_neg;
          neg_b_d  = rt_neg;
          dvz_d    = (rt_data == '0);
          cnt_d    = CNT_LAST;
          // mult: multiplier in low half; div: dividend in low half
          opb_d    = op[1] ? rt_mag : rs_mag;
          acc_d    = op[1] ? {{WIDTH{1'b0}}, rs_mag}
                           : {{WIDTH{1'b0}}, rt_mag};
        end else if (!start) begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_d = div_diff[WIDTH]
                  ? {acc_q[2*WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) state_d = S_FIN;
          else             cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dz_d   = is_div_q & dvz_q;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = dvz_q ? {WIDTH{1'b1}} : quo;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dvz_q    <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dvz_q    <= dvz_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = (state_q != S_IDLE);
  assign stall_req = busy | (start & ~flush);
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized bench for muldiv_ctrl against an arithmetic model.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_req;
  logic        done;
  logic        div_zero;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic void model(input logic [1:0] o,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h,
                                output logic [31:0] l,
                                output logic z);
    longint      sa, sb, p;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    z  = 1'b0;
    h  = '0;
    l  = '0;
    case (o)
      2'd0: begin p = sa * sb; {h, l} = p; end
      2'd1: begin u = {32'b0, a} * {32'b0, b}; {h, l} = u; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = '1; z = 1'b1;
        end else if (o == 2'd2) begin
          l = 32'(sa / sb); h = 32'(sa % sb);
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op now and waits for its done; leaves time in the done cycle.
  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ez;
    int          n, nb;
    model(o, a, b, eh, el, ez);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    #1;
    chk("stall_issue", stall_req, 1);
    tick();
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 0; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      tick();
      n++;
    end
    chk("latency", n, 33);
    chk("busy_cycles", nb, 33);
    chk("busy_at_done", busy, 0);
    chk("hi", hi, eh);
    chk("lo", lo, el);
    chk("div_zero", div_zero, ez);
    m_hi = eh; m_lo = el;
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    mthi = h; mtlo = l; wdata = d;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    repeat (cycles) begin
      tick();
      if (done) nd++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nd;
    logic [1:0]  o;
    logic [31:0] a, b;
    rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
    flush = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_stall", stall_req, 0);
    rst_n = 1'b1;
    tick();

    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    tick();
    chk("done_once", done, 0);
    do_op(2'd0, 32'hFFFFFFFD, 32'd7);
    do_op(2'd2, 32'hFFFFFFF9, 32'd2);
    do_op(2'd3, 32'd100, 32'd7);
    do_op(2'd3, 32'h12345678, 32'd0);
    do_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    do_op(2'd2, 32'h80000000, 32'd0);
    tick();

    start = 1'b1; flush = 1'b1; op = 2'd1;
    #1;
    chk("stall_flush", stall_req, 0);
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", busy, 0);

    mt(1'b1, 1'b0, 32'hAAAA5555);
    start = 1'b1; op = 2'd1; rs_data = 32'd2; rt_data = 32'd3;
    tick();
    start = 1'b0;
    repeat (3) tick();
    mtlo = 1'b1; wdata = 32'hDEADBEEF;
    tick();
    mtlo = 1'b0;
    chk("mtlo_busy", lo, m_lo);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_hi", hi, 32'hAAAA5555);
    chk("flush_lo", lo, m_lo);
    count_done(40, nd);
    chk("flush_no_done", nd, 0);
    mt(1'b1, 1'b1, 32'h0F0F1234);

    start = 1'b1; op = 2'd0; rs_data = 32'd9; rt_data = 32'd9;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    tick();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_hi", hi, 0);
    chk("rstmid_lo", lo, 0);
    chk("rstmid_stall", stall_req, 0);
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    count_done(40, nd);
    chk("rstmid_no_done", nd, 0);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'h80000000;
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      do_op(o, a, b);
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          tick();
          chk("rand_done_low", done, 0);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multi-cycle multiply/divide sequencer sitting beside the EX stage.
- Accepts MULT/MULTU/DIV/DIVU issued from EX, iterates one bit per cycle, and owns the architectural HI/LO registers.
- Raises a stall request toward the hazard logic while busy.
- Aborts on exception flush, when the EX-stage exception vector is nonzero.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  issue strobe from EX, sampled on rising edge
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  input  WIDTH  forwarded rs operand (multiplicand/dividend)
- rt_data  input  WIDTH  forwarded rt operand (multiplier/divisor)
- flush  input  1  abort in-flight operation (exception)
- mthi  input  1  write wdata to HI
- mtlo  input  1  write wdata to LO
- wdata  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in flight
- stall_req  output  1  combinational: busy | (start & ~flush)
- done  output  1  one-cycle pulse when HI/LO commit
- div_zero  output  1  one-cycle pulse with done when a divide had rt=0

Behaviour:
- Reset: one clock is fixed; reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: rst_n=0 at an edge gives state IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0. Any in-flight operation is discarded.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 & flush=0 captures op, the operand magnitudes (abs value for signed ops) and the sign bits, loads counter=WIDTH-1, and moves to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Performs one radix-2 step per cycle.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, giving remainder in the upper half and quotient in the lower half.
  - When counter=0, go to FIN; else decrement the counter.
  - Exactly WIDTH CALC cycles.
- FIN, sign fixup:
  - MULT: negate the 2*WIDTH product if the sign bits differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - At the edge leaving FIN: commit HI (product upper / remainder) and LO (product lower / quotient), set done=1 for one cycle, and return to IDLE.
- Latency: start sampled at edge E0 means busy=1 from E0 to E0+WIDTH+1, and HI/LO/done are valid after edge E0+WIDTH+1 (33 edges for WIDTH=32).
- Divide by zero: iteration still runs the full latency; result is HI=rs_data, LO=all ones (unsigned and signed alike); div_zero pulses with done.
- DIV 0x80000000 / -1: result LO=0x80000000, HI=0, with no flag.
- start while busy: ignored; no queueing. The EX stage is held by stall_req.
- flush:
  - In CALC or FIN: next state IDLE, HI/LO unchanged, no done.
  - With start in IDLE: start is ignored.
- mthi/mtlo:
  - Honoured only in IDLE with start=0; they write at that edge.
  - Ignored while busy.
  - mthi and mtlo together write both registers.
- The FIN commit has priority over nothing: FIN occurs only while busy, so MTHI/MTLO cannot coincide with it.
- Back-to-back issue: a start is accepted in the cycle where done=1 (state IDLE).
- Reset mid-operation: reset overrides everything; rst_n=0 during CALC gives state IDLE and hi/lo=0 next edge.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done pulses once, busy high for 33 cycles.
- MULT rs=-3 (0xFFFFFFFD), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU rs=100, rt=7 issued in the done cycle -> lo=14, hi=2.
- DIVU rs=0x12345678, rt=0 -> hi=0x12345678, lo=0xFFFFFFFF, div_zero=1 coincident with done.
- MTHI 0xAAAA5555 in IDLE, then MULTU 2*3 with flush at CALC cycle 10 -> hi stays 0xAAAA5555, no done, busy drops next edge; an MTLO attempted while busy is ignored.
- rst_n=0 at CALC cycle 5 -> next edge busy=0, hi=lo=0, stall_req=0; no done afterwards.
